// File: rtl/riscv_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_mem_arb_pkg : state encoding and owner constants for riscv_mem_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package riscv_mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef logic owner_t;

  localparam owner_t OWN_IF = 1'b0;
  localparam owner_t OWN_DM = 1'b1;

  localparam logic [3:0] BE_WORD = 4'hF;

  // Data side wins unless fetch is waiting and the DM streak has saturated.
  function automatic owner_t pick_owner(input logic if_req, input logic dm_req,
                                        input logic streak_full);
    if (dm_req && !(if_req && streak_full)) begin
      return OWN_DM;
    end
    return OWN_IF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_mem_arbiter_if : fetch, data and memory-port signals of the arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              i_if_flush;
  logic [31:0]       o_if_rdata;
  logic              o_if_valid;
  logic              o_stall_if;

  logic              i_dm_req;
  logic              i_dm_we;
  logic [ADDR_W-1:0] i_dm_addr;
  logic [31:0]       i_dm_wdata;
  logic [3:0]        i_dm_be;
  logic [31:0]       o_dm_rdata;
  logic              o_dm_valid;
  logic              o_stall_dm;

  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_be;
  logic              i_mem_gnt;
  logic              i_mem_rvalid;
  logic [31:0]       i_mem_rdata;

  // Arbiter side
  modport slave (
    input  i_if_req, i_if_addr, i_if_flush,
    output o_if_rdata, o_if_valid, o_stall_if,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
    output o_dm_rdata, o_dm_valid, o_stall_dm,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  // Core and memory side
  modport master (
    output i_if_req, i_if_addr, i_if_flush,
    input  o_if_rdata, o_if_valid, o_stall_if,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
    input  o_dm_rdata, o_dm_valid, o_stall_dm,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_mem_arbiter : shares one memory port between fetch and data stages
// Revision: 1.0
// ----------------------------------------------------------------------------
module riscv_mem_arbiter
  import riscv_mem_arb_pkg::*;
#(
  parameter int DM_STREAK = 4,
  parameter int ADDR_W    = 32
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  riscv_mem_arbiter_if.slave bus
);

  localparam int              SW         = $clog2(DM_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(DM_STREAK);

  logic [1:0]        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              w_streak_full;
  owner_t            w_winner;
  logic              w_resp;
  logic              w_if_valid;
  logic              w_dm_valid;

  assign w_streak_full = (streak_q == STREAK_MAX);
  assign w_winner      = pick_owner(bus.i_if_req, bus.i_dm_req, w_streak_full);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    drop_d   = drop_q;
    streak_d = streak_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (bus.i_if_req || bus.i_dm_req) begin
          owner_d = w_winner;
          state_d = ST_REQ;
          if (w_winner == OWN_DM) begin
            we_d    = bus.i_dm_we;
            addr_d  = bus.i_dm_addr;
            wdata_d = bus.i_dm_wdata;
            be_d    = bus.i_dm_be;
            if (!bus.i_if_req) begin
              streak_d = '0;
            end else if (!w_streak_full) begin
              streak_d = streak_q + SW'(1);
            end
          end else begin
            we_d     = 1'b0;
            addr_d   = bus.i_if_addr;
            wdata_d  = '0;
            be_d     = BE_WORD;
            streak_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (bus.i_mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.i_mem_rvalid) begin
          rdata_d = bus.i_mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flushed fetch still completes at the memory, only its result is dropped.
    if (state_q != ST_IDLE && owner_q == OWN_IF && bus.i_if_flush) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      drop_q   <= 1'b0;
      streak_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      streak_q <= streak_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
    end
  end

  // A flush arriving in the response cycle itself also kills the pulse.
  assign w_resp     = (state_q == ST_RESP);
  assign w_if_valid = w_resp && (owner_q == OWN_IF) && !drop_q && !bus.i_if_flush;
  assign w_dm_valid = w_resp && (owner_q == OWN_DM);

  assign bus.o_if_valid  = w_if_valid;
  assign bus.o_dm_valid  = w_dm_valid;
  assign bus.o_if_rdata  = rdata_q;
  assign bus.o_dm_rdata  = rdata_q;
  assign bus.o_stall_if  = bus.i_if_req && !w_if_valid;
  assign bus.o_stall_dm  = bus.i_dm_req && !w_dm_valid;

  assign bus.o_mem_req   = (state_q == ST_REQ);
  assign bus.o_mem_we    = we_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_be    = be_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_riscv_mem_arbiter : directed and randomized checks against a transaction model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_riscv_mem_arbiter;

  localparam int DM_STREAK = 4;
  localparam int ADDR_W    = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_mem_arbiter #(.DM_STREAK(DM_STREAK), .ADDR_W(ADDR_W)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic        m_active  = 1'b0;
  logic        m_granted = 1'b0;
  logic        m_resp    = 1'b0;
  logic        m_drop    = 1'b0;
  logic        m_own     = 1'b0;   // 0 fetch, 1 data
  int          m_streak  = 0;
  logic        m_we      = 1'b0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_wdata   = '0;
  logic [3:0]  m_be      = '0;
  logic [31:0] m_data    = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active = 1'b0; m_granted = 1'b0; m_resp = 1'b0; m_drop = 1'b0; m_own = 1'b0;
      m_streak = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_data = '0;
    end else if (m_resp) begin
      m_resp = 1'b0; m_active = 1'b0; m_granted = 1'b0; m_drop = 1'b0;
    end else if (m_active) begin
      if (bus.i_if_flush && !m_own) m_drop = 1'b1;
      if (!m_granted) begin
        if (bus.i_mem_gnt) m_granted = 1'b1;
      end else if (bus.i_mem_rvalid) begin
        m_data = bus.i_mem_rdata;
        m_resp = 1'b1;
      end
    end else if (bus.i_if_req || bus.i_dm_req) begin
      m_active = 1'b1; m_granted = 1'b0; m_drop = 1'b0;
      if (bus.i_if_req && (!bus.i_dm_req || m_streak == DM_STREAK)) begin
        m_own = 1'b0; m_we = 1'b0; m_addr = bus.i_if_addr; m_wdata = '0; m_be = 4'hF;
        m_streak = 0;
      end else begin
        m_own = 1'b1; m_we = bus.i_dm_we; m_addr = bus.i_dm_addr;
        m_wdata = bus.i_dm_wdata; m_be = bus.i_dm_be;
        m_streak = bus.i_if_req ? ((m_streak + 1 > DM_STREAK) ? DM_STREAK : m_streak + 1) : 0;
      end
    end
  end

  // ---------------- every-cycle comparison ----------------
  always @(negedge clk) begin
    logic e_ifv, e_dmv;
    #2;
    e_ifv = m_resp && !m_own && !m_drop && !bus.i_if_flush;
    e_dmv = m_resp && m_own;
    chk("mem_req",   32'(bus.o_mem_req),  32'(m_active && !m_granted));
    chk("mem_we",    32'(bus.o_mem_we),   32'(m_we));
    chk("mem_addr",  bus.o_mem_addr,      m_addr);
    chk("mem_wdata", bus.o_mem_wdata,     m_wdata);
    chk("mem_be",    32'(bus.o_mem_be),   32'(m_be));
    chk("if_valid",  32'(bus.o_if_valid), 32'(e_ifv));
    chk("dm_valid",  32'(bus.o_dm_valid), 32'(e_dmv));
    chk("if_rdata",  bus.o_if_rdata,      m_data);
    chk("dm_rdata",  bus.o_dm_rdata,      m_data);
    chk("stall_if",  32'(bus.o_stall_if), 32'(bus.i_if_req && !e_ifv));
    chk("stall_dm",  32'(bus.o_stall_dm), 32'(bus.i_dm_req && !e_dmv));
  end

  // ---------------- requesters and memory stub ----------------
  logic [31:0] if_q[$];
  req_t        dm_q[$];
  logic [31:0] rd_q[$];
  req_t        iss_log[$];

  bit rand_mode = 0, stray_rv = 0, pend = 0, if_done = 0, dm_done = 0, if_kill = 0, prev_req = 0;
  int gnt_dly = 0, rv_dly = 0, gcnt = 0, rcnt = 0, cyc = 0, flush_at = -1;
  int n_if_valid, n_dm_valid, n_stall_if, n_memreq, last_if_cyc, last_dm_cyc;
  logic [31:0] last_if_rdata, last_dm_rdata;

  task automatic clear_stats();
    n_if_valid = 0; n_dm_valid = 0; n_stall_if = 0; n_memreq = 0;
    last_if_cyc = -1; last_dm_cyc = -1; last_if_rdata = '0; last_dm_rdata = '0;
    iss_log.delete();
  endtask

  task automatic cycle(input bit hold_rst);
    req_t r;
    @(negedge clk);
    cyc++;
    if (hold_rst) begin
      rstn = 1'b0;
      if_q.delete(); dm_q.delete(); rd_q.delete();
      pend = 0; gcnt = 0; rcnt = 0; if_done = 0; dm_done = 0; if_kill = 0;
      bus.i_if_req = 0; bus.i_dm_req = 0; bus.i_if_flush = 0;
      bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0;
    end else begin
      rstn = 1'b1;
      if ((if_done || if_kill) && if_q.size() > 0) void'(if_q.pop_front());
      if (dm_done && dm_q.size() > 0) void'(dm_q.pop_front());
      if (rand_mode) begin
        if (if_q.size() == 0 && $urandom_range(0, 3) == 0) if_q.push_back($urandom & 32'hFFFF_FFFC);
        if (dm_q.size() == 0 && $urandom_range(0, 3) == 0) begin
          r.we = 1'($urandom_range(0, 1)); r.addr = $urandom; r.wdata = $urandom; r.be = 4'($urandom);
          dm_q.push_back(r);
        end
      end
      bus.i_if_req  = (if_q.size() > 0);
      bus.i_if_addr = (if_q.size() > 0) ? if_q[0] : '0;
      bus.i_if_flush = rand_mode ? (bus.i_if_req && $urandom_range(0, 15) == 0) : (cyc == flush_at);
      if_kill = bus.i_if_flush && bus.i_if_req;
      bus.i_dm_req = (dm_q.size() > 0);
      if (dm_q.size() > 0) begin
        bus.i_dm_we = dm_q[0].we; bus.i_dm_addr = dm_q[0].addr;
        bus.i_dm_wdata = dm_q[0].wdata; bus.i_dm_be = dm_q[0].be;
      end else begin
        bus.i_dm_we = 0; bus.i_dm_addr = '0; bus.i_dm_wdata = '0; bus.i_dm_be = '0;
      end
      bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = $urandom;
      if (pend) begin
        if (rcnt >= rv_dly) begin
          bus.i_mem_rvalid = 1;
          bus.i_mem_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
          pend = 0; rcnt = 0;
        end else rcnt++;
      end else if (bus.o_mem_req) begin
        if (gcnt >= gnt_dly) begin
          bus.i_mem_gnt = 1; pend = 1; gcnt = 0; rcnt = 0;
          if (rand_mode) begin gnt_dly = $urandom_range(0, 3); rv_dly = $urandom_range(0, 3); end
        end else gcnt++;
      end else if (stray_rv || (rand_mode && $urandom_range(0, 7) == 0)) begin
        bus.i_mem_rvalid = 1;
        bus.i_mem_gnt    = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    #3;
    if_done = bus.o_if_valid; dm_done = bus.o_dm_valid;
    if (bus.o_if_valid) begin n_if_valid++; last_if_cyc = cyc; last_if_rdata = bus.o_if_rdata; end
    if (bus.o_dm_valid) begin n_dm_valid++; last_dm_cyc = cyc; last_dm_rdata = bus.o_dm_rdata; end
    if (bus.o_stall_if) n_stall_if++;
    if (bus.o_mem_req) n_memreq++;
    if (bus.o_mem_req && !prev_req) begin
      r.we = bus.o_mem_we; r.addr = bus.o_mem_addr; r.wdata = bus.o_mem_wdata; r.be = bus.o_mem_be;
      iss_log.push_back(r);
    end
    prev_req = bus.o_mem_req;
  endtask

  task automatic run_quiet(input int limit);
    int n = 0;
    do begin
      cycle(0);
      n++;
    end while ((m_active || if_q.size() > 0 || dm_q.size() > 0 || pend || if_kill) && n < limit);
    if (n >= limit) begin
      n_checks++; n_err++;
      $display("FAIL timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] exp_addr);
    if (iss_log.size() > idx) chk(name, iss_log[idx].addr, exp_addr);
    else chk(name, 32'hFFFF_FFFF, exp_addr);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0;
    req_t r;
    bus.i_if_req = 0; bus.i_if_addr = '0; bus.i_if_flush = 0;
    bus.i_dm_req = 0; bus.i_dm_we = 0; bus.i_dm_addr = '0; bus.i_dm_wdata = '0; bus.i_dm_be = '0;
    bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
    clear_stats();
    repeat (3) cycle(1);
    chk("rst_mem_req", 32'(bus.o_mem_req), 32'h0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'h0);
    chk("rst_if_rdata", bus.o_if_rdata, 32'h0);

    // Lone fetch, best-case memory
    clear_stats(); gnt_dly = 0; rv_dly = 0;
    if_q.push_back(32'h100); rd_q.push_back(32'hDEADBEEF); c0 = cyc + 1;
    run_quiet(50);
    chk("t1_latency", 32'(last_if_cyc - c0), 32'd3);
    chk("t1_rdata", last_if_rdata, 32'hDEADBEEF);
    chk("t1_stall_cycles", 32'(n_stall_if), 32'd3);
    chk_log("t1_addr", 0, 32'h100);

    // Simultaneous fetch and store: store first
    clear_stats();
    r.we = 1; r.addr = 32'h300; r.wdata = 32'h12345678; r.be = 4'b0011;
    dm_q.push_back(r); if_q.push_back(32'h200);
    run_quiet(50);
    chk_log("t2_first_addr", 0, 32'h300);
    if (iss_log.size() > 0) begin
      chk("t2_first_we", 32'(iss_log[0].we), 32'd1);
      chk("t2_first_be", 32'(iss_log[0].be), 32'h3);
      chk("t2_first_wdata", iss_log[0].wdata, 32'h12345678);
    end
    chk_log("t2_second_addr", 1, 32'h200);
    if (iss_log.size() > 1) chk("t2_second_be", 32'(iss_log[1].be), 32'hF);
    chk("t2_if_stall_cycles", 32'(n_stall_if), 32'd7);

    // Streak: six loads while fetch is held
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      r.we = 0; r.addr = 32'h1000 + 32'(4 * i); r.wdata = '0; r.be = 4'hF;
      dm_q.push_back(r);
    end
    if_q.push_back(32'h2000);
    run_quiet(100);
    chk_log("t3_g0", 0, 32'h1000);
    chk_log("t3_g1", 1, 32'h1004);
    chk_log("t3_g2", 2, 32'h1008);
    chk_log("t3_g3", 3, 32'h100C);
    chk_log("t3_g4", 4, 32'h2000);
    chk_log("t3_g5", 5, 32'h1010);

    // Flush while fetch waits for its response
    clear_stats(); rv_dly = 2;
    if_q.push_back(32'h500); if_q.push_back(32'h400);
    rd_q.push_back(32'hAAAA5555); rd_q.push_back(32'h0BADF00D);
    c0 = cyc + 1; flush_at = c0 + 2;
    run_quiet(60);
    flush_at = -1;
    chk("t4_if_valid_count", 32'(n_if_valid), 32'd1);
    chk("t4_rdata", last_if_rdata, 32'h0BADF00D);
    chk_log("t4_refetch_addr", 1, 32'h400);

    // Slow grant and slow response
    clear_stats(); gnt_dly = 3; rv_dly = 2;
    r.we = 0; r.addr = 32'h3000; r.wdata = '0; r.be = 4'hF;
    dm_q.push_back(r); rd_q.push_back(32'h55AA00FF); c0 = cyc + 1;
    run_quiet(60);
    chk("t5_req_cycles", 32'(n_memreq), 32'd4);
    chk("t5_latency", 32'(last_dm_cyc - c0), 32'd8);
    chk("t5_valid_count", 32'(n_dm_valid), 32'd1);
    chk("t5_rdata", last_dm_rdata, 32'h55AA00FF);

    // Reset during WAIT, then a stray response
    clear_stats(); gnt_dly = 0; rv_dly = 3;
    r.we = 0; r.addr = 32'h4000; r.wdata = '0; r.be = 4'hF;
    dm_q.push_back(r);
    repeat (3) cycle(0);
    cycle(1);
    chk("t6_rst_mem_req", 32'(bus.o_mem_req), 32'h0);
    chk("t6_rst_mem_addr", bus.o_mem_addr, 32'h0);
    chk("t6_rst_dm_valid", 32'(bus.o_dm_valid), 32'h0);
    chk("t6_rst_dm_rdata", bus.o_dm_rdata, 32'h0);
    cycle(1);
    stray_rv = 1; cycle(0); stray_rv = 0;
    clear_stats();
    repeat (4) cycle(0);
    chk("t6_no_req_after", 32'(n_memreq), 32'h0);
    chk("t6_no_valid_after", 32'(n_dm_valid + n_if_valid), 32'h0);

    // Randomized traffic
    rand_mode = 1;
    repeat (3000) cycle(0);
    rand_mode = 0; gnt_dly = 0; rv_dly = 0;
    run_quiet(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
